gene_net_analyzer: RTL and testbench
====================================

# gene_net_analyzer

Eight-gene synchronous Boolean gene-regulatory-network stepper with attractor detection. Each clock it registers the successor of the applied network state. Two monitors watch that output: a fixed-point detector (the state equals its predecessor) and a cycle detector (any state revisited since the last reset). The block sits under a state-space sweep harness that seeds an initial state, feeds `next_status` back to `status_in`, and reads `is_fixed` and `is_cycle` to classify the attractor reached.

## Interface
Parameters:
- none. Width is fixed at 8 genes, giving a 256-state space.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high; clears monitor history.
- `status_in`  input  [0:7]  current network state; bit 0 = gene x0 (leftmost/MSB of literals).
- `next_status`  output  [0:7]  registered successor state f(`status_in`).
- `is_fixed`  output  1  registered; latest sampled state equals the previous sample.
- `is_cycle`  output  1  registered, sticky; some sampled state was seen earlier since reset.

## Operation
Update function f, evaluated on `status_in` = x0..x7:
- n0 = x7
- n1 = x0, n2 = x1, n3 = x2
- n4 = x3 | (x0 & x7)
- n5 = x4, n6 = x5, n7 = x6

Network register:
- `next_status` <= f(`status_in`) every edge, including reset cycles, so a seed applied during reset propagates.
- Reset does not clear `next_status`. Its power-up value is don't-care until the first edge.

Fixed-point monitor:
- Holds `prev[0:7]` and `prev_valid`.
- Reset edge: `prev_valid` <= 0, `is_fixed` <= 0.
- Otherwise: `is_fixed` <= `prev_valid` & (`next_status` == `prev`); `prev` <= `next_status`; `prev_valid` <= 1.
- Not sticky.

Cycle monitor:
- Holds a 256-bit `visited` vector indexed by the 8-bit state.
- Reset edge: `visited` <= all 0, `is_cycle` <= 0.
- Otherwise, with s = `next_status`:
  - if `visited[s]` (pre-edge value) then `is_cycle` <= 1;
  - `visited[s]` <= 1.
- `is_cycle` holds at 1 until reset.
- A fixed point counts as a cycle of length 1.

Monitors sample `next_status` only; the seed state itself is never recorded.

## Timing
- Reset values after a reset edge: `is_fixed` = 0, `is_cycle` = 0, history empty. `next_status` = f(`status_in`) sampled at that edge.
- Network latency: 1 edge from `status_in` to `next_status`.
- Monitor latency: a state appearing on `next_status` after edge k is classified at edge k+1.
- Read and write of the same `visited` entry on one edge: the read sees the old value.
- Reset asserted mid-trajectory: all history is discarded on that edge, and detection restarts from the following sample.
- Reset has priority over every monitor update.
- With feedback (`status_in` = `next_status`) and reset on edge 0, `is_cycle` rises within 256 + 1 edges after the reset edge for any seed.

## Test plan
- Combinational map: `status_in`=8'b10000001 -> `next_status`=8'b11001000 after one edge. `status_in`=8'b01010101 -> 8'b10101010.
- Fixed point, seed 8'h00 with reset on edge 0 and feedback: `next_status` stays 8'h00; `is_fixed`=1 and `is_cycle`=1 after edge 2, both 0 after edges 0–1. Same result for seed 8'hFF.
- Period-2 cycle, seed 8'b01010101 with feedback: samples alternate 10101010/01010101; `is_cycle` rises after edge 3; `is_fixed` stays 0.
- Period-8 cycle, seed 8'b10000000 with feedback: samples walk the single 1 right (01000000 … 00000001, 10000000); `is_cycle` rises after edge 9, `is_fixed` never 1.
- Reset mid-run: after `is_cycle`=1 on the 8'b01010101 loop, assert reset for one edge with seed 8'b10000000 -> both outputs 0 after that edge, then `is_cycle` rises again 9 edges later.
- Exhaustive sweep: each of the 256 seeds run 256 fed-back edges after reset -> `is_cycle`=1 at the end for every seed. `is_fixed`=1 at the end only for trajectories ending at 8'h00 or 8'hFF.

Source files
------------

// File: rtl/gene_net_if.sv
// Bus between the sweep harness and the gene-network stepper.
//   status_in   : current network state applied by the harness
//   next_status : registered successor state f(status_in)
//   is_fixed    : latest sample equals the previous sample
//   is_cycle    : sticky; some sample was revisited since reset
// Gene x0 is the MSB of an 8-bit literal, so gene xi sits in bit (7 - i).
interface gene_net_if;
  logic [7:0] status_in;
  logic [7:0] next_status;
  logic       is_fixed;
  logic       is_cycle;

  modport master (
    output status_in,
    input  next_status,
    input  is_fixed,
    input  is_cycle
  );

  modport slave (
    input  status_in,
    output next_status,
    output is_fixed,
    output is_cycle
  );
endinterface

// File: rtl/gene_net_analyzer.sv
// Eight-gene synchronous Boolean network stepper with attractor detection.
// Each edge registers f(status_in). Two monitors watch the registered state:
// a fixed-point detector (sample equals previous sample) and a sticky cycle
// detector (some sample was already seen since reset).
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high; clears monitor history only
//   bus   : gene_net_if slave (status_in in; next_status, is_fixed, is_cycle out)
module gene_net_analyzer (
  input  logic       clk,
  input  logic       reset,
  gene_net_if.slave  bus
);

  logic [7:0]   f_next;
  logic [7:0]   state_q;
  logic [7:0]   prev_q;
  logic         prev_valid_q;
  logic         is_fixed_q;
  logic         is_cycle_q;
  logic [255:0] visited_q;

  // Update rule with gene xi in bit (7 - i): a rotate toward the LSB end,
  // except gene x4 also switches on when x0 and x7 are both active.
  always_comb begin
    f_next    = '0;
    f_next[7] = bus.status_in[0];
    f_next[6] = bus.status_in[7];
    f_next[5] = bus.status_in[6];
    f_next[4] = bus.status_in[5];
    f_next[3] = bus.status_in[4] | (bus.status_in[7] & bus.status_in[0]);
    f_next[2] = bus.status_in[3];
    f_next[1] = bus.status_in[2];
    f_next[0] = bus.status_in[1];
  end

  // Network register is not reset so a seed applied during reset propagates.
  always_ff @(posedge clk) begin
    state_q <= f_next;
  end

  // Monitors sample the pre-edge network state; the seed itself is never recorded.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_valid_q <= 1'b0;
      is_fixed_q   <= 1'b0;
      is_cycle_q   <= 1'b0;
      visited_q    <= '0;
    end else begin
      is_fixed_q   <= prev_valid_q & (state_q == prev_q);
      prev_q       <= state_q;
      prev_valid_q <= 1'b1;
      // Read of visited_q sees the pre-edge value, so a first visit never flags.
      if (visited_q[state_q]) begin
        is_cycle_q <= 1'b1;
      end
      visited_q[state_q] <= 1'b1;
    end
  end

  assign bus.next_status = state_q;
  assign bus.is_fixed    = is_fixed_q;
  assign bus.is_cycle    = is_cycle_q;

endmodule

// File: tb/tb_gene_net_analyzer.sv
module tb_gene_net_analyzer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gene_net_if bus ();

  gene_net_analyzer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: trajectory history kept as a plain list of samples.
  logic [7:0] m_next;
  bit   [7:0] m_hist[$];
  bit         m_fixed;
  bit         m_cycle;

  function automatic logic [7:0] f_ref(input logic [7:0] s);
    logic x[8];
    logic n[8];
    for (int i = 0; i < 8; i++) x[i] = s[7-i];
    n[0] = x[7];
    n[1] = x[0];
    n[2] = x[1];
    n[3] = x[2];
    n[4] = x[3] | (x[0] & x[7]);
    n[5] = x[4];
    n[6] = x[5];
    n[7] = x[6];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

  task automatic model_edge(input bit rst, input logic [7:0] din);
    if (rst) begin
      m_hist.delete();
      m_fixed = 1'b0;
      m_cycle = 1'b0;
    end else begin
      m_fixed = (m_hist.size() > 0) && (m_hist[$] == m_next);
      foreach (m_hist[i]) if (m_hist[i] == m_next) m_cycle = 1'b1;
      m_hist.push_back(m_next);
    end
    m_next = f_ref(din);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock edge: drive, advance model, sample 1 time unit after the edge.
  task automatic do_edge(input bit rst, input logic [7:0] din);
    reset         = rst;
    bus.status_in = din;
    @(posedge clk);
    model_edge(rst, din);
    #1;
    check("next_status", bus.next_status, m_next);
    check("is_fixed", {7'd0, bus.is_fixed}, {7'd0, m_fixed});
    check("is_cycle", {7'd0, bus.is_cycle}, {7'd0, m_cycle});
  endtask

  // Reset with seed on edge 0, then n-1 fed-back edges; report first rise edges.
  task automatic run_feedback(input string name, input logic [7:0] seed, input int n,
                              input int exp_fix_rise, input int exp_cyc_rise);
    int fr = -1;
    int cr = -1;
    do_edge(1'b1, seed);
    check({name, "_rst_fixed"}, {7'd0, bus.is_fixed}, 8'd0);
    check({name, "_rst_cycle"}, {7'd0, bus.is_cycle}, 8'd0);
    for (int k = 1; k < n; k++) begin
      do_edge(1'b0, bus.next_status);
      if (fr < 0 && bus.is_fixed === 1'b1) fr = k;
      if (cr < 0 && bus.is_cycle === 1'b1) cr = k;
    end
    check_int({name, "_fixed_rise_edge"}, fr, exp_fix_rise);
    check_int({name, "_cycle_rise_edge"}, cr, exp_cyc_rise);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_next;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'h81, 8'hC8};
    tbl[1] = '{8'h55, 8'hAA};
    tbl[2] = '{8'h00, 8'h00};
    tbl[3] = '{8'hFF, 8'hFF};
    tbl[4] = '{8'h80, 8'h40};
    tbl[5] = '{8'h01, 8'h80};
    tbl[6] = '{8'h10, 8'h08};
    tbl[7] = '{8'h09, 8'h84};
    tbl[8] = '{8'h88, 8'h44};

    reset         = 1'b1;
    bus.status_in = 8'h00;

    // Combinational map, each applied on a reset edge (monitors held clear).
    for (int i = 0; i < 9; i++) begin
      do_edge(1'b1, tbl[i].din);
      check("map_next", bus.next_status, tbl[i].exp_next);
      check("map_fixed", {7'd0, bus.is_fixed}, 8'd0);
      check("map_cycle", {7'd0, bus.is_cycle}, 8'd0);
    end

    // Attractor sequences; the 0x80 run resets in the middle of the 0x55 loop.
    run_feedback("fix00", 8'h00, 4, 2, 2);
    run_feedback("fixFF", 8'hFF, 4, 2, 2);
    run_feedback("per2", 8'h55, 6, -1, 3);
    check("per2_cycle_before_reset", {7'd0, bus.is_cycle}, 8'd1);
    run_feedback("per8", 8'h80, 14, -1, 9);

    // Random inputs with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      do_edge(($urandom_range(0, 31) == 0), 8'($urandom_range(0, 255)));
    end

    // Exhaustive seed sweep with feedback.
    for (int s = 0; s < 256; s++) begin
      do_edge(1'b1, 8'(s));
      for (int k = 0; k < 256; k++) do_edge(1'b0, bus.next_status);
      check("sweep_cycle", {7'd0, bus.is_cycle}, 8'd1);
      check("sweep_fixed", {7'd0, bus.is_fixed},
            {7'd0, (m_next == 8'h00) || (m_next == 8'hFF)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
